// File: rtl/kanade_pkg.sv
// Shared kanade32 encodings: ALU op codes, opcode/funct values and datapath mux selects.
// Values are fixed by the existing ALU and datapath, so do not renumber them.
package kanade_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUB_REG     = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

endpackage

// File: rtl/funct_dec.sv
// Combinational R-type funct decoder; shared with the pipelined control path.
// Unknown funct codes report valid=0 and fall back to ADD.
module funct_dec
    import kanade_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for kanade32: sequences fetch/decode/execute/mem/writeback.
// Outputs are Moore-decoded from state, except mem_ready/zero gating of ir_write and pc_en.
module mc_ctrl
    import kanade_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_e;

    state_e state_q, state_d;

    logic [2:0] fd_alu_op;
    logic       fd_valid;

    logic       pc_write, pc_write_cond;
    logic       mem_read_c, mem_write_c, iord_c, ir_write_c, pc_en_c;
    logic [1:0] pc_source_c, alu_src_b_c;
    logic       alu_src_a_c;
    logic [2:0] alu_op_c;
    logic       reg_write_c, reg_dst_c, mem_to_reg_c, illegal_c;

    funct_dec u_funct_dec (
        .funct  (funct),
        .alu_op (fd_alu_op),
        .valid  (fd_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        iord_c        = 1'b0;
        ir_write_c    = 1'b0;
        pc_source_c   = PCSRC_ALU;
        alu_src_a_c   = 1'b0;
        alu_src_b_c   = ALUB_REG;
        alu_op_c      = ALU_ADD;
        reg_write_c   = 1'b0;
        reg_dst_c     = 1'b0;
        mem_to_reg_c  = 1'b0;
        illegal_c     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = ALUB_FOUR;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively here into ALUOut.
                alu_src_b_c = ALUB_IMM_SH2;
                case (opcode)
                    OPC_RTYPE:      state_d = S_R_EXEC;
                    OPC_LW, OPC_SW: state_d = S_MEM_ADDR;
                    OPC_BEQ:        state_d = S_BRANCH;
                    OPC_J:          state_d = S_JUMP;
                    OPC_ADDI:       state_d = S_I_EXEC;
                    default:        state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = fd_alu_op;
                state_d     = fd_valid ? S_R_WB : S_ILLEGAL;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = ALUB_IMM;
                state_d     = (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = ALUB_IMM;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c   = 1'b1;
                alu_op_c      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source_c   = PCSRC_ALUOUT;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write    = 1'b1;
                pc_source_c = PCSRC_JUMP;
                state_d     = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
            end
            default: state_d = S_ILLEGAL;
        endcase

        pc_en_c = pc_write | (pc_write_cond & zero);
    end

    // Reset masks every output combinationally so an in-flight request drops instantly.
    assign mem_read   = mem_read_c   & ~rst;
    assign mem_write  = mem_write_c  & ~rst;
    assign iord       = iord_c       & ~rst;
    assign ir_write   = ir_write_c   & ~rst;
    assign pc_en      = pc_en_c      & ~rst;
    assign pc_source  = rst ? 2'd0 : pc_source_c;
    assign alu_src_a  = alu_src_a_c  & ~rst;
    assign alu_src_b  = rst ? 2'd0 : alu_src_b_c;
    assign alu_op     = rst ? 3'd0 : alu_op_c;
    assign reg_write  = reg_write_c  & ~rst;
    assign reg_dst    = reg_dst_c    & ~rst;
    assign mem_to_reg = mem_to_reg_c & ~rst;
    assign illegal    = illegal_c    & ~rst;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the kanade32 core. It decodes the 6-bit opcode/funct of the instruction held in the IR and sequences fetch, decode, execute, memory and writeback over several cycles. It sits directly upstream of the ALU: it drives the ALU operation code and operand selects, consumes the ALU `zero` flag for branches, and drives the PC, IR, register-file and memory enables.

## Interface
- No parameters.
- `clk` input 1 — core clock; all state changes on the rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `opcode` input 6 — IR[31:26]; stable from the end of FETCH.
- `funct` input 6 — IR[5:0].
- `zero` input 1 — ALU zero flag.
- `mem_ready` input 1 — memory completes the current access this cycle.
- `mem_read`, `mem_write` output 1 — memory access request; held until `mem_ready`.
- `iord` output 1 — memory address source: 0 = PC, 1 = ALUOut.
- `ir_write` output 1 — IR load enable.
- `pc_en` output 1 — PC load enable, equal to `pc_write | (pc_write_cond & zero)`.
- `pc_source` output 2 — PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `alu_src_a` output 1 — ALU operand A: 0 = PC, 1 = A register.
- `alu_src_b` output 2 — ALU operand B: 0 = B register, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `alu_op` output 3 — ALU operation, using the shared ALU encodings.
- `reg_write` output 1 — register-file write enable.
- `reg_dst` output 1 — destination register: 0 = rt, 1 = rd.
- `mem_to_reg` output 1 — writeback source: 0 = ALUOut, 1 = MDR.
- `illegal` output 1 — sticky flag for an undecodable instruction.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ILLEGAL.
- FETCH:
  - Asserts `mem_read=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=1`, `alu_op=ADD`, `pc_source=0`.
  - Stays in FETCH while `mem_ready=0`.
  - When `mem_ready=1`: `ir_write=1` and `pc_write=1` in the same cycle, then goes to DECODE.
- DECODE: `alu_src_a=0`, `alu_src_b=3`, `alu_op=ADD` (branch target into ALUOut). Next state by opcode:
  - 0x00 -> R_EXEC
  - 0x23 (lw) or 0x2B (sw) -> MEM_ADDR
  - 0x04 (beq) -> BRANCH
  - 0x02 (j) -> JUMP
  - 0x08 (addi) -> I_EXEC
  - any other opcode -> ILLEGAL
- R_EXEC: `alu_src_a=1`, `alu_src_b=0`, `alu_op` from funct:
  - 0x20 -> ADD, 0x22 -> SUB, 0x24 -> AND, 0x25 -> OR, 0x2A -> SLT.
  - Any other funct -> ILLEGAL instead of R_WB.
- R_WB: `reg_write=1`, `reg_dst=1`, `mem_to_reg=0`, then FETCH.
- MEM_ADDR: `alu_src_a=1`, `alu_src_b=2`, `alu_op=ADD`. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read=1`, `iord=1`; waits on `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write=1`, `reg_dst=0`, `mem_to_reg=1`, then FETCH.
- MEM_WR: `mem_write=1`, `iord=1`; waits on `mem_ready`, then FETCH.
- I_EXEC: `alu_src_a=1`, `alu_src_b=2`, `alu_op=ADD`, then I_WB.
- I_WB: `reg_write=1`, `reg_dst=0`, `mem_to_reg=0`, then FETCH.
- BRANCH: `alu_src_a=1`, `alu_src_b=0`, `alu_op=SUB`, `pc_write_cond=1`, `pc_source=1`, then FETCH.
- JUMP: `pc_write=1`, `pc_source=2`, then FETCH.
- ILLEGAL:
  - Absorbing state; only `rst` leaves it.
  - `illegal=1`; all enables (`mem_*`, `ir_write`, `pc_en`, `reg_write`) are 0.
- Any output not listed for a state is 0. `alu_op` defaults to ADD.

## Timing
- Reset:
  - Asynchronous; state goes to FETCH immediately.
  - While `rst=1`, every output is forced to 0.
  - The first fetch request is issued in the first cycle after deassertion.
- Outputs are decoded combinationally from the state register. The only exceptions are `ir_write` and `pc_en` in FETCH (gated by `mem_ready`) and `pc_en` in BRANCH (gated by `zero`).
- Latency with zero-wait memory (`mem_ready` tied to 1), in cycles:
  - j: 3
  - beq: 3
  - R-type: 4
  - addi: 4
  - sw: 4
  - lw: 5
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Handshake: `mem_read`/`mem_write` stay asserted and `iord` stays constant until the cycle `mem_ready=1`. `mem_ready` is ignored outside the three memory states.
- Reset mid-access drops the request the same instant. Memory treats a dropped request as cancelled.

## Structure
- Shared package `kanade_pkg` holds:
  - the ALU op codes, at the existing values shared with the ALU: AND=0, OR=1, ADD=2, SUB=6, SLT=7;
  - the opcode and funct constants;
  - the `pc_source` and `alu_src_b` encodings.
- The state enum stays local to `mc_ctrl`.
- One sub-module: `funct_dec`, a combinational funct -> {`alu_op`, `valid`} decoder, reused later by a pipelined control path.

## Test plan
- Reset and zero-wait fetch: reset, `mem_ready=1`, opcode 0x00, funct 0x22.
  - Required sequence: FETCH, DECODE, R_EXEC with `alu_op=6`, R_WB with `reg_write=1`, `reg_dst=1`, then FETCH in cycle 5.
- lw with two wait cycles on MEM_RD: opcode 0x23.
  - `mem_read=1`, `iord=1` held for 3 cycles.
  - `reg_write=1` with `mem_to_reg=1` exactly 1 cycle after `mem_ready`.
  - Total 7 cycles.
- beq: opcode 0x04.
  - `zero=1` -> `pc_en=1`, `pc_source=1` in BRANCH.
  - `zero=0` -> `pc_en=0`.
  - Both cases return to FETCH after 3 cycles.
- Illegal input:
  - opcode 0x3F -> `illegal=1` from the cycle after DECODE; no enable ever asserts again.
  - Repeat with opcode 0x00, funct 0x00 -> ILLEGAL after R_EXEC.
  - `rst` pulse clears `illegal`.
- Async reset during MEM_WR wait: all outputs 0 in the same cycle, without waiting for a clock edge; after release, FETCH with `mem_read=1`.
- Fetch stall: hold `mem_ready=0` for 4 cycles in FETCH.
  - `ir_write=0` and `pc_en=0` throughout.
  - Both pulse for exactly 1 cycle when `mem_ready` rises.
